// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD-line receive path: sequencer states,
// default response geometry and response field widths.
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    RESP,
    CRC,
    END
  } cmd_rx_state_e;

  localparam int DEF_RESP_BITS = 48;
  localparam int DEF_CRC_BITS  = 7;
  localparam int DEF_NCR_MAX   = 64;

  localparam int CMD_IDX_W = 6;
  localparam int CMD_ARG_W = 32;

endpackage

// File: rtl/cmd_resp_rx_ctrl.sv
// Response receive sequencer for the SD CMD line: waits for the start bit,
// shifts in index/argument, gates the CRC deserializer and checks framing.
module cmd_resp_rx_ctrl
  import sd_cmd_pkg::*;
#(
  parameter int RESP_BITS = DEF_RESP_BITS,
  parameter int CRC_BITS  = DEF_CRC_BITS,
  parameter int NCR_MAX   = DEF_NCR_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cmd_in,
  input  logic [CRC_BITS-1:0]  deser_data,
  output logic                 deser_enable,
  output logic                 deser_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic                 frame_err,
  output logic [CMD_IDX_W-1:0] resp_index,
  output logic [CMD_ARG_W-1:0] resp_arg,
  output logic [CRC_BITS-1:0]  resp_crc
);

  // Bits between start bit and CRC: transmission bit, index, argument.
  localparam int SHIFT_W = RESP_BITS - CRC_BITS - 2;
  localparam int WCNT_W  = $clog2(NCR_MAX + 1);

  localparam logic [5:0]        RESP_LAST = 6'(SHIFT_W - 1);
  localparam logic [5:0]        CRC_LAST  = 6'(CRC_BITS - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(NCR_MAX - 1);

  cmd_rx_state_e      state;
  logic [WCNT_W-1:0]  wait_cnt;
  logic [5:0]         bit_cnt;
  logic [SHIFT_W-1:0] shift_q;

  assign busy         = (state != IDLE);
  assign deser_enable = (state == CRC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      deser_reset <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      frame_err   <= 1'b0;
      resp_index  <= '0;
      resp_arg    <= '0;
      resp_crc    <= '0;
    end else begin
      done        <= 1'b0;
      deser_reset <= 1'b1;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          bit_cnt  <= '0;
          if (start) begin
            state       <= WAIT_START;
            timeout_err <= 1'b0;
            frame_err   <= 1'b0;
            deser_reset <= 1'b0;
          end
        end
        WAIT_START: begin
          // A start bit on the last allowed sample takes priority over timeout.
          if (!cmd_in) begin
            state   <= RESP;
            bit_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        RESP: begin
          shift_q <= {shift_q[SHIFT_W-2:0], cmd_in};
          if (bit_cnt == RESP_LAST) begin
            state   <= CRC;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        CRC: begin
          if (bit_cnt == CRC_LAST) begin
            state <= END;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        END: begin
          frame_err  <= !cmd_in || shift_q[SHIFT_W-1];
          resp_crc   <= deser_data;
          resp_index <= shift_q[CMD_ARG_W +: CMD_IDX_W];
          resp_arg   <= shift_q[CMD_ARG_W-1:0];
          done       <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
